// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: dual-port IMem read bus, redirect request and the
// valid/ready instruction handoff toward decode.
interface ifetch_queue_if;
    logic [5:0]  imem_a1;
    logic [5:0]  imem_a2;
    logic [31:0] imem_rd1;
    logic [31:0] imem_rd2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [15:0] delivered_cnt;

    modport master (
        output imem_a1, imem_a2, inst_valid, inst, inst_pc, delivered_cnt,
        input  imem_rd1, imem_rd2, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_a1, imem_a2, inst_valid, inst, inst_pc, delivered_cnt,
        output imem_rd1, imem_rd2, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: pulls up to two sequential words per cycle from a
// dual-read-port IMem and hands them to decode one per cycle.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input logic           clk,
    input logic           rst_n,
    ifetch_queue_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fpc;
    logic [31:0]   q_inst [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_p1;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [15:0]   dcnt;
    logic [1:0]    npush;
    logic          pop;

    assign bus.imem_a1       = fpc[7:2];
    assign bus.imem_a2       = fpc[7:2] + 6'd1;
    assign bus.inst_valid    = (count != '0) & ~bus.redirect_valid;
    assign bus.inst          = q_inst[head];
    assign bus.inst_pc       = q_pc[head];
    assign bus.delivered_cnt = dcnt;

    assign pop     = bus.inst_valid & bus.inst_ready;
    assign tail_p1 = tail + PW'(1);
    // Space is judged on the registered count; a same-cycle pop frees nothing.
    assign free    = CW'(QDEPTH) - count;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        npush = 2'd0;
        if (free >= CW'(2))
            npush = 2'd2;
        else if (free == CW'(1))
            npush = 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // reader sees pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc   <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            dcnt  <= '0;
            // NOTE: queue storage is cleared too, so inst/inst_pc read as 0
            // out of reset instead of stale words.
            for (int i = 0; i < QDEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (bus.redirect_valid) begin
            fpc   <= {bus.redirect_pc[31:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (npush != 2'd0) begin
                q_inst[tail] <= bus.imem_rd1;
                q_pc[tail]   <= fpc;
            end
            if (npush == 2'd2) begin
                q_inst[tail_p1] <= bus.imem_rd2;
                q_pc[tail_p1]   <= fpc + 32'd4;
            end
            tail  <= tail + PW'(npush);
            fpc   <= fpc + {28'd0, npush, 2'b00};
            count <= count + CW'(npush) - CW'(pop);
            if (pop) begin
                head <= head + PW'(1);
                if (dcnt != 16'hFFFF)
                    dcnt <= dcnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a queue-level model checked every cycle, plus
// directed scenarios with literal expectations from the team program.
module tb_ifetch_queue;
    localparam int QDEPTH = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic clk;
    logic rst_n;
    ifetch_queue_if bus ();

    ifetch_queue #(.RESET_PC(32'h0), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] rom [64];
    assign bus.imem_rd1 = rom[bus.imem_a1];
    assign bus.imem_rd2 = rom[bus.imem_a2];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an ordered list of {inst, pc}, the fetch PC and a delivery count.
    entry_t      mq[$];
    logic [31:0] m_fpc     = 32'h0;
    logic [15:0] m_dcnt    = 16'h0;
    logic        m_started = 1'b0;
    int          m_free;
    logic        m_pop;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (!rst_n) begin
            mq.delete();
            m_fpc  = 32'h0;
            m_dcnt = 16'h0;
        end else if (bus.redirect_valid) begin
            mq.delete();
            m_fpc = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            m_free = QDEPTH - mq.size();
            m_pop  = (mq.size() != 0) && bus.inst_ready;
            if (m_pop) begin
                void'(mq.pop_front());
                if (m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
            end
            if (m_free >= 1) mq.push_back('{inst: rom[m_fpc[7:2]], pc: m_fpc});
            if (m_free >= 2) mq.push_back('{inst: rom[(m_fpc + 32'd4) >> 2 & 32'h3F], pc: m_fpc + 32'd4});
            m_fpc = m_fpc + 32'(4 * ((m_free >= 2) ? 2 : m_free));
        end
    end

    logic exp_v;
    always @(negedge clk) begin
        if (m_started) begin
            exp_v = (mq.size() != 0) && !bus.redirect_valid;
            check("cmp_valid", {31'd0, bus.inst_valid}, {31'd0, exp_v});
            if (exp_v) begin
                check("cmp_inst", bus.inst, mq[0].inst);
                check("cmp_pc", bus.inst_pc, mq[0].pc);
            end
            check("cmp_dcnt", {16'd0, bus.delivered_cnt}, {16'd0, m_dcnt});
            check("cmp_a1", {26'd0, bus.imem_a1}, {26'd0, m_fpc[7:2]});
            check("cmp_a2", {26'd0, bus.imem_a2}, {26'd0, m_fpc[7:2] + 6'd1});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string nm, input logic [31:0] ei, input logic [31:0] ep);
        @(negedge clk);
        check({nm, "_valid"}, {31'd0, bus.inst_valid}, 32'd1);
        check({nm, "_inst"}, bus.inst, ei);
        check({nm, "_pc"}, bus.inst_pc, ep);
    endtask

    task automatic redirect_to(input logic [31:0] addr, input logic [5:0] ea1, input logic [5:0] ea2);
        logic [15:0] d0;
        cyc();
        d0 = m_dcnt;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = addr;
        bus.inst_ready     = 1'b1;
        @(negedge clk);
        check("redir_masked", {31'd0, bus.inst_valid}, 32'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_empty", {31'd0, bus.inst_valid}, 32'd0);
        check("redir_dcnt", {16'd0, bus.delivered_cnt}, {16'd0, d0});
        check("redir_a1", {26'd0, bus.imem_a1}, {26'd0, ea1});
        check("redir_a2", {26'd0, bus.imem_a2}, {26'd0, ea2});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hE000_0000 | i;
        rom[0] = 32'h34080005; rom[1] = 32'h3409000A;
        rom[2] = 32'h01095021; rom[3] = 32'h01285823;
        rom[4] = 32'hAD0A0000; rom[5] = 32'h8D0C0000;
        rom[6] = 32'h114C0002; rom[7] = 32'h3C0D1234;

        rst_n = 1'b0;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset state and first-fetch latency
        @(negedge clk);
        check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_pc", bus.inst_pc, 32'h0);
        check("rst_dcnt", {16'd0, bus.delivered_cnt}, 32'd0);
        check("rst_a1", {26'd0, bus.imem_a1}, 32'd0);
        check("rst_a2", {26'd0, bus.imem_a2}, 32'd1);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("lat_valid", {31'd0, bus.inst_valid}, 32'd0);
        expect_head("p0", 32'h34080005, 32'h00);
        expect_head("p1", 32'h3409000A, 32'h04);
        expect_head("p2", 32'h01095021, 32'h08);
        expect_head("p3", 32'h01285823, 32'h0C);
        expect_head("p4", 32'hAD0A0000, 32'h10);
        expect_head("p5", 32'h8D0C0000, 32'h14);
        @(negedge clk);
        check("dcnt6", {16'd0, bus.delivered_cnt}, 32'd6);

        // Stall after reset: queue fills, head holds
        cyc();
        rst_n = 1'b0;
        bus.inst_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        @(negedge clk);
        check("stall_count", mq.size(), 32'd4);
        check("stall_a1", {26'd0, bus.imem_a1}, 32'd4);
        check("stall_inst", bus.inst, 32'h34080005);
        check("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
        cyc();
        bus.inst_ready = 1'b1;
        expect_head("s0", 32'h34080005, 32'h00);
        expect_head("s1", 32'h3409000A, 32'h04);
        expect_head("s2", 32'h01095021, 32'h08);
        expect_head("s3", 32'h01285823, 32'h0C);
        expect_head("s4", 32'hAD0A0000, 32'h10);

        // Redirect while full
        cyc();
        bus.inst_ready = 1'b0;
        repeat (5) cyc();
        check("full_before_redir", mq.size(), 32'd4);
        redirect_to(32'h18, 6'd6, 6'd7);
        expect_head("r18a", 32'h114C0002, 32'h18);
        expect_head("r18b", 32'h3C0D1234, 32'h1C);

        // Wrap of fetch address across word 63
        redirect_to(32'hF8, 6'd62, 6'd63);
        expect_head("rF8a", 32'hE000003E, 32'hF8);
        expect_head("rF8b", 32'hE000003F, 32'hFC);
        expect_head("rF8c", 32'h34080005, 32'h100);
        redirect_to(32'hFC, 6'd63, 6'd0);
        expect_head("rFCa", 32'hE000003F, 32'hFC);
        expect_head("rFCb", 32'h34080005, 32'h100);

        // Unaligned redirect
        redirect_to(32'h1A, 6'd6, 6'd7);
        expect_head("r1Aa", 32'h114C0002, 32'h18);
        expect_head("r1Ab", 32'h3C0D1234, 32'h1C);

        // Mid-stream reset with full queue
        cyc();
        bus.inst_ready = 1'b0;
        repeat (5) cyc();
        check("full_before_rst", mq.size(), 32'd4);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        check("mrst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("mrst_inst", bus.inst, 32'h0);
        check("mrst_dcnt", {16'd0, bus.delivered_cnt}, 32'd0);
        expect_head("m0", 32'h34080005, 32'h00);
        expect_head("m1", 32'h3409000A, 32'h04);
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch controller that sequences the dual-read-port instruction memory (64 words, 6-bit word address, combinational read) and buffers fetched words in a small queue for the decode stage. It uses both IMem read ports to fetch up to two sequential words per cycle, delivers one instruction per cycle through a valid/ready handshake, and flushes and refetches on a branch/jump redirect. It sits between the PC/branch logic and the decoder and replaces direct PC-to-IMem wiring.

## Interface

- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- QDEPTH, 4, queue entries (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_a1  out  6  IMem port 1 word address = fpc[7:2]
- imem_a2  out  6  IMem port 2 word address = fpc[7:2]+1, mod 64
- imem_rd1  in  32  IMem port 1 data, same-cycle combinational
- imem_rd2  in  32  IMem port 2 data, same-cycle combinational
- redirect_valid  in  1  flush queue and restart fetch
- redirect_pc  in  32  new byte address; bits [1:0] ignored
- inst_valid  out  1  head entry available
- inst  out  32  head instruction word
- inst_pc  out  32  byte address of head instruction
- inst_ready  in  1  decoder accepts head this cycle
- delivered_cnt  out  16  instructions handed off since reset, saturating at 16'hFFFF

## Operation

- State: fpc (32-bit fetch PC), circular queue of QDEPTH {inst, pc} entries, head/tail pointers, count (0..QDEPTH), delivered_cnt.
- pop = inst_valid & inst_ready.
- free = QDEPTH − count, computed from registered count only; a same-cycle pop does not add space.
- Push rule (no redirect, rst_n high): free ≥ 2 → enqueue {imem_rd1, fpc}, then {imem_rd2, fpc+4}; fpc += 8. free = 1 → enqueue {imem_rd1, fpc}; fpc += 4. free = 0 → no push; fpc holds.
- count_next = count + pushes − pop. Pops come from head in enqueue order.
- fpc arithmetic is 32-bit modulo 2^32. IMem addresses use fpc[7:2], so fetch wraps from word 63 to word 0 while inst_pc continues to increment (0xFC → 0x100).
- Redirect has top priority. count, head, and tail go to 0. fpc is set to {redirect_pc[31:2], 2'b00}. There is no push in that cycle. A handshake in that cycle is not counted as a pop.
- inst_valid = (count ≠ 0) & ~redirect_valid. The redirect term is combinational masking.
- delivered_cnt increments by 1 on each pop and saturates.
- Reset (rst_n low at an edge) applies at any time, including mid-operation: fpc ← RESET_PC, count/head/tail ← 0, all queue storage ← 0, delivered_cnt ← 0. There is no push during reset.

## Timing

- Reset values: inst_valid 0, inst 0, inst_pc 0, delivered_cnt 0; imem_a1 = RESET_PC[7:2], imem_a2 = RESET_PC[7:2]+1.
- Fetch-to-valid latency: 1 cycle. The first edge with rst_n high pushes 2 words, and inst_valid is 1 in the following cycle.
- Redirect latency: redirect asserted in cycle N → push from new fpc in N+1 → inst_valid with inst_pc = redirect target in N+2.
- With inst_ready held high, the steady state delivers one instruction per cycle with no bubbles. A single push per cycle is sufficient once count ≥ 1.
- Full queue with pop: no push that cycle, count → QDEPTH−1, and a single push follows the next cycle. inst_valid stays high throughout.
- inst and inst_pc are stable while inst_valid & ~inst_ready, until the next redirect or reset.

## Test plan

- **Reset release, inst_ready = 1, IMem loaded with the team program:**
  - Cycle 1 onward delivers, one per cycle:
    - 34080005 @0x00
    - 3409000A @0x04
    - 01095021 @0x08
    - 01285823 @0x0C
    - AD0A0000 @0x10
    - 8D0C0000 @0x14
  - delivered_cnt = 6 after six pops.
- **inst_ready = 0 for 10 cycles after reset:**
  - count = 4, fpc = 0x10, inst = 34080005 held.
  - Raising ready yields pcs 0x00, 0x04, 0x08, 0x0C, 0x10, … with no bubble.
- **Redirect to 0x18 while the queue is full:**
  - Next cycle inst_valid = 0.
  - The following cycles deliver 114C0002 @0x18, then 3C0D1234 @0x1C.
  - delivered_cnt does not count the redirect-cycle handshake.
- **Redirect to 0xF8:**
  - Delivers ROM[62] @0xF8, ROM[63] @0xFC, then 34080005 @0x100.
  - imem_a2 = 0 when fpc = 0xFC.
- **Redirect to 0x1A (unaligned):** behaves exactly as 0x18; first inst_pc = 0x18.
- **rst_n low for one edge mid-stream with the queue full:**
  - Next cycle inst_valid = 0, inst = 0, delivered_cnt = 0.
  - Delivery restarts at 34080005 @RESET_PC two cycles after rst_n rises.
